majority_filter_sequencer: RTL and testbench
============================================

Name: majority_filter_sequencer

Overview:
- Iteratively applies the 3-bit sliding-window majority filter to a 5-bit operand, up to a programmed iteration count.
- Stops early when the operand reaches a fixpoint, meaning one more application would not change it.
- Sits between the operand/button front end and the 7-segment digit mux of the mini-project calculator.
- Owns the start/busy/done handshake and the registered digit outputs.

Parameters:
- WIDTH, 5, operand/result bit width (fixed at 5 for this project; no other value is supported).
- ITER_W, 3, width of the iteration counter; maximum iteration count is 2^ITER_W-1 = 7.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to begin a run; sampled only in IDLE.
- operand_x  in  5  initial operand, latched when start is accepted.
- hidden  in  1  pad bit placed at both ends of the window, latched with the operand.
- iter_count  in  3  maximum number of filter applications, latched with the operand.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  single-cycle pulse; result fields are valid from this cycle onward.
- result  out  5  final filtered word.
- iterations_used  out  3  number of filter applications actually performed.
- stable  out  1  1 if result is a fixpoint of the filter.
- d1  out  4  display digit: {1'b0, iterations_used}.
- d2..d6  out  4 each  display digits: {3'b0, result[4]} .. {3'b0, result[0]}.

Behaviour:
- Filter function f(s, h):
  - t = {h, s[4:0], h} (7 bits).
  - f[k] = majority(t[k+2], t[k+1], t[k]) for k = 0..4.
  - Purely combinational; no ties are possible with three inputs.
- State machine: IDLE and RUN. Registers: work[4:0], pad, limit[2:0], cnt[2:0].
- IDLE:
  - start=1 at an edge loads work<=operand_x, pad<=hidden, limit<=iter_count, cnt<=0.
  - Same edge sets busy<=1, done<=0 and moves to RUN.
  - Otherwise the machine holds and done<=0.
- RUN, one decision per edge. Let nxt = f(work, pad).
  - If cnt==limit OR nxt==work: terminate.
    - result<=work, iterations_used<=cnt, stable<=(nxt==work).
    - d1..d6 updated, done<=1, busy<=0, state<=IDLE.
  - Else: work<=nxt, cnt<=cnt+1.
- Latency: done is high k+1 cycles after the start-sampling edge, where k = iterations_used. Worst case is 8 cycles.
- iter_count=0: terminates on the first RUN edge with result=operand_x and iterations_used=0; stable still reports the fixpoint test.
- Fixpoint reached at the same edge as cnt==limit: terminate, stable=1.
- start while busy: ignored. The latched operand, pad and limit are unaffected by input changes during RUN.
- start high in the done cycle: accepted, since the machine is already in IDLE. Result fields hold until the next termination.
- done is never asserted for two consecutive cycles.
- Reset (any state, including mid-RUN) forces:
  - state IDLE; busy, done, stable = 0;
  - result, iterations_used, work, cnt, limit, pad = 0;
  - d1..d6 = 4'h0.
- No partial result is ever presented.
- Counter width: cnt never exceeds limit ≤ 7, so it cannot wrap.

Decomposition:
- Shared package (mini_project_pkg):
  - WIDTH=5 and ITER_W=3;
  - state encoding constants ST_IDLE=1'b0, ST_RUN=1'b1;
  - DIGIT_W=4.
- Sub-module maj3_window_filter: combinational, inputs s[4:0] and h, output f[4:0].
  - Instantiated once, driven by work/pad.
  - The bench reuses it as the reference model.
- Everything else (FSM, counters, output registers) lives in the top block.

Test Plan:
- Reset mid-run: start with hidden=0, X=10101, iter=7; assert reset 2 cycles later. Expect next cycle busy=0, done=0, result=0, d1..d6=0, and the next start behaves normally.
- Limit-bounded run: hidden=0, X=10101, iter=2. Expect done 3 cycles after start, result=00100, iterations_used=2, stable=0, d1=4'h2, d2..d6=0,0,1,0,0.
- Convergence: hidden=0, X=10101, iter=7. Sequence 01010→00100→00000, then fixpoint. Expect done 4 cycles after start, result=00000, iterations_used=3, stable=1.
- Early fixpoint after one step: hidden=0, X=10110, iter=5. Expect 10110→01110, done 2 cycles after start, result=01110, iterations_used=1, stable=1.
- Immediate fixpoint and zero limit:
  - hidden=1, X=00000, iter=4: done 1 cycle after start, result=00000, used=0, stable=1.
  - hidden=0, X=10110, iter=0: done 1 cycle after start, result=10110, used=0, stable=0.
- Handshake:
  - Pulse start again while busy, and change operand_x mid-run: result is unaffected.
  - Hold start high through done: a second run begins the cycle after done with no lost or duplicated done pulse.

Source files
------------

// File: rtl/mini_project_pkg.sv
// Shared constants and types for the majority-filter sequencer slice of the
// calculator mini project.
package mini_project_pkg;

  localparam int WIDTH   = 5;
  localparam int ITER_W  = 3;
  localparam int DIGIT_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/majority_filter_sequencer_if.sv
// Operand/control and result/display bundle between the calculator front end
// and the sequencer; the sequencer binds the slave modport.
interface majority_filter_sequencer_if;
  import mini_project_pkg::*;

  // Handshake: start is sampled only while idle, and the operand, hidden and
  // iter_count fields are latched on that same edge. busy is high from the
  // next cycle until done; done is a one-cycle pulse, and the result fields
  // are valid from the done cycle and hold until the next done.
  logic               start;
  logic [WIDTH-1:0]   operand_x;
  logic               hidden;
  logic [ITER_W-1:0]  iter_count;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic [ITER_W-1:0]  iterations_used;
  logic               stable;
  logic [DIGIT_W-1:0] d1;
  logic [DIGIT_W-1:0] d2;
  logic [DIGIT_W-1:0] d3;
  logic [DIGIT_W-1:0] d4;
  logic [DIGIT_W-1:0] d5;
  logic [DIGIT_W-1:0] d6;
  logic               state;

  modport master (
    output start, operand_x, hidden, iter_count,
    input  busy, done, result, iterations_used, stable,
    input  d1, d2, d3, d4, d5, d6, state
  );

  modport slave (
    input  start, operand_x, hidden, iter_count,
    output busy, done, result, iterations_used, stable,
    output d1, d2, d3, d4, d5, d6, state
  );

endinterface

// File: rtl/maj3_window_filter.sv
// One application of the 3-bit sliding-window majority filter, with the pad
// bit h placed at both ends of the 5-bit word.
module maj3_window_filter
  import mini_project_pkg::*;
(
  input  logic [WIDTH-1:0] s,
  input  logic             h,
  output logic [WIDTH-1:0] f
);

  logic [WIDTH+1:0] t;

  assign t = {h, s, h};

  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    assign f[k] = (t[k+2] & t[k+1]) | (t[k+1] & t[k]) | (t[k+2] & t[k]);
  end

endmodule

// File: rtl/majority_filter_sequencer.sv
// Runs the majority filter repeatedly on a latched operand until the
// iteration limit or a fixpoint, then presents result and display digits.
module majority_filter_sequencer
  import mini_project_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  majority_filter_sequencer_if.slave  bus
);

  state_t            state_q;
  state_t            state_d;
  logic [WIDTH-1:0]  work;
  logic              pad;
  logic [ITER_W-1:0] limit;
  logic [ITER_W-1:0] cnt;
  logic [WIDTH-1:0]  nxt;
  logic              accept;
  logic              finish;
  logic              advance;
  logic              busy_q;
  logic              done_q;
  logic              stable_q;
  logic [WIDTH-1:0]  result_q;
  logic [ITER_W-1:0] used_q;

  maj3_window_filter u_filter (
    .s (work),
    .h (pad),
    .f (nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (finish)    state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A fixpoint and the limit may coincide; either one ends the run.
  always_comb begin
    accept  = (state_q == ST_IDLE) && bus.start;
    finish  = (state_q == ST_RUN) && ((cnt == limit) || (nxt == work));
    advance = (state_q == ST_RUN) && !finish;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      work     <= '0;
      pad      <= 1'b0;
      limit    <= '0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      stable_q <= 1'b0;
      result_q <= '0;
      used_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        work   <= bus.operand_x;
        pad    <= bus.hidden;
        limit  <= bus.iter_count;
        cnt    <= '0;
        busy_q <= 1'b1;
      end
      if (advance) begin
        work <= nxt;
        cnt  <= cnt + 1'b1;
      end
      if (finish) begin
        result_q <= work;
        used_q   <= cnt;
        stable_q <= (nxt == work);
        busy_q   <= 1'b0;
        done_q   <= 1'b1;
      end
    end
  end

  // Digits are fixed rewirings of registered fields, so they change only at done.
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.result          = result_q;
  assign bus.iterations_used = used_q;
  assign bus.stable          = stable_q;
  assign bus.d1              = {1'b0, used_q};
  assign bus.d2              = {3'b000, result_q[4]};
  assign bus.d3              = {3'b000, result_q[3]};
  assign bus.d4              = {3'b000, result_q[2]};
  assign bus.d5              = {3'b000, result_q[1]};
  assign bus.d6              = {3'b000, result_q[0]};
  assign bus.state           = state_q;

endmodule

// File: tb/tb_majority_filter_sequencer.sv
// Bench for majority_filter_sequencer: directed handshake cases plus random
// runs compared against a behavioural filter model.
module tb_majority_filter_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  majority_filter_sequencer_if bus ();

  majority_filter_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Each output bit is the majority of itself and its two neighbours; the
  // neighbour beyond either end of the word is the pad bit.
  function automatic logic [4:0] ref_filter(input logic [4:0] s, input logic h);
    logic [4:0] f;
    int ones;
    for (int k = 0; k < 5; k++) begin
      ones = int'(s[k]);
      ones += (k == 4) ? int'(h) : int'(s[(k + 1) % 5]);
      ones += (k == 0) ? int'(h) : int'(s[(k + 4) % 5]);
      f[k] = (ones >= 2);
    end
    return f;
  endfunction

  // Returns {stable, iterations_used, result}.
  function automatic logic [8:0] ref_run(input logic [4:0] x, input logic h, input int lim);
    logic [4:0] w = x;
    int steps = 0;
    while (steps < lim && ref_filter(w, h) != w) begin
      w = ref_filter(w, h);
      steps++;
    end
    return {ref_filter(w, h) == w, 3'(steps), w};
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},   bus.busy, 0);
    check({tag, "_done"},   bus.done, 0);
    check({tag, "_result"}, bus.result, 0);
    check({tag, "_used"},   bus.iterations_used, 0);
    check({tag, "_stable"}, bus.stable, 0);
    check({tag, "_digits"}, {bus.d1, bus.d2, bus.d3, bus.d4, bus.d5, bus.d6}, 0);
    check({tag, "_state"},  bus.state, 0);
  endtask

  // Counts negedges until done; start is dropped after every step.
  task automatic wait_done(input int exp_lat);
    int lat = 0;
    while (bus.done !== 1'b1 && lat < 16) begin
      @(negedge clk);
      lat++;
      bus.start = 1'b0;
    end
    check("latency", lat, exp_lat);
  endtask

  task automatic check_result();
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      check("exp_queue_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check("result", bus.result, e[4:0]);
    check("iterations_used", bus.iterations_used, e[7:5]);
    check("stable", bus.stable, e[8]);
    check("d1", bus.d1, {1'b0, e[7:5]});
    check("d2_d6", {bus.d2, bus.d3, bus.d4, bus.d5, bus.d6},
          {3'b0, e[4], 3'b0, e[3], 3'b0, e[2], 3'b0, e[1], 3'b0, e[0]});
  endtask

  task automatic do_run(input logic [4:0] x, input logic h, input logic [2:0] lim, input bit poke);
    logic [8:0] e;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.operand_x  = x;
    bus.hidden     = h;
    bus.iter_count = lim;
    e = ref_run(x, h, int'(lim));
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    if (poke) begin
      bus.start      = 1'b1;
      bus.operand_x  = 5'($urandom_range(0, 31));
      bus.hidden     = ~h;
      bus.iter_count = 3'($urandom_range(0, 7));
    end
    wait_done(int'(e[7:5]) + 1);
    check("busy_at_done", bus.busy, 0);
    check_result();
    @(negedge clk);
    check("done_single", bus.done, 0);
    check("idle_after_done", bus.busy, 0);
  endtask

  initial begin
    logic [8:0] ea;
    logic [8:0] eb;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.operand_x  = '0;
    bus.hidden     = 1'b0;
    bus.iter_count = '0;
    repeat (3) @(negedge clk);
    check_reset_state("por");
    reset = 1'b0;

    do_run(5'b10101, 1'b0, 3'd2, 1'b0);
    check("limit_run_value", bus.result, 5'b00100);

    // Reset two cycles into a long run.
    @(negedge clk);
    bus.start      = 1'b1;
    bus.operand_x  = 5'b10101;
    bus.hidden     = 1'b0;
    bus.iter_count = 3'd7;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("mid_run_reset");
    repeat (6) begin
      @(negedge clk);
      check("no_done_after_reset", bus.done, 0);
    end

    do_run(5'b10101, 1'b0, 3'd7, 1'b0);
    check("converge_stable", bus.stable, 1);
    do_run(5'b10110, 1'b0, 3'd5, 1'b0);
    check("one_step_value", bus.result, 5'b01110);
    do_run(5'b00000, 1'b1, 3'd4, 1'b0);
    do_run(5'b10110, 1'b0, 3'd0, 1'b0);
    check("zero_limit_stable", bus.stable, 0);
    do_run(5'b10101, 1'b0, 3'd7, 1'b1);

    // Hold start through done: second run starts on the edge after done.
    @(negedge clk);
    bus.start      = 1'b1;
    bus.operand_x  = 5'b10101;
    bus.hidden     = 1'b0;
    bus.iter_count = 3'd7;
    ea = ref_run(5'b10101, 1'b0, 7);
    exp_q.push_back(ea);
    @(negedge clk);
    check("hold_busy_a", bus.busy, 1);
    begin
      int lat = 0;
      while (bus.done !== 1'b1 && lat < 16) begin
        @(negedge clk);
        lat++;
      end
      check("hold_latency_a", lat, int'(ea[7:5]) + 1);
    end
    check_result();
    bus.operand_x  = 5'b01101;
    bus.hidden     = 1'b1;
    bus.iter_count = 3'd6;
    eb = ref_run(5'b01101, 1'b1, 6);
    exp_q.push_back(eb);
    @(negedge clk);
    bus.start = 1'b0;
    check("hold_no_double_done", bus.done, 0);
    check("hold_busy_b", bus.busy, 1);
    wait_done(int'(eb[7:5]) + 1);
    check_result();
    @(negedge clk);
    check("hold_done_single", bus.done, 0);

    for (int i = 0; i < 40; i++) begin
      do_run(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    check("exp_queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
